word_symbol_serializer: RTL
===========================

Name: word_symbol_serializer

Overview:
- Parametrised successor to the decoder's word-to-symbol front end.
- Buffers incoming code words in a small FIFO and unloads each word as WORD_W/SYM_W symbols of SYM_W bits each, toward the Viterbi branch-metric unit.
- Adds valid/ready handshakes on both sides, per-word symbol order selection, frame delimiting and back-to-back word streaming with no bubble.

Parameters:
- WORD_W, 16, input word width; must be a multiple of SYM_W.
- SYM_W, 2, output symbol width (code rate 1/SYM_W).
- DEPTH, 4, input FIFO depth in words; power of two, at least 2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_in_valid  in  1  input word valid.
- o_in_ready  out  1  FIFO can accept a word.
- i_in_data  in  WORD_W  code word.
- i_in_last  in  1  word is the last of its frame.
- i_msb_first  in  1  symbol order, captured per word at push.
- o_sym_valid  out  1  symbol valid.
- i_sym_ready  in  1  downstream accepts the symbol.
- o_sym_data  out  SYM_W  current symbol.
- o_sym_last  out  1  final symbol of a frame-last word.
- o_word_end  out  1  final symbol of any word.
- o_done  out  1  one-cycle frame-complete pulse.
- o_level  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (i_rst high at an edge): FIFO empties and the FSM goes to IDLE. After that edge all outputs are 0 except o_in_ready, which is 1.
- While i_rst is high, o_in_ready is forced to 0.
- Reset mid-word discards the shift register and all FIFO contents; no o_done is generated.
- Input side:
  - A push occurs on an edge where i_in_valid and o_in_ready are both high. The FIFO stores {i_in_data, i_in_last, i_msb_first}.
  - o_in_ready = !full, combinational from registered state.
  - There is no write-through when full, even if a pop occurs in the same cycle.
- Constants: N = WORD_W/SYM_W; symbol counter width is $clog2(N).
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the shift register, set counter = N-1, go to SHIFT. Otherwise stay.
  - SHIFT: o_sym_valid = 1. On a handshake (i_sym_ready high):
    - if counter > 0: shift by SYM_W and decrement;
    - if counter == 0 and the FIFO is non-empty: pop the next word, stay in SHIFT (zero-bubble);
    - if counter == 0 and the FIFO is empty: go to IDLE.
- Latency: a word pushed at edge k (into an empty FIFO, FSM in IDLE) gives o_sym_valid high after edge k+1. Two words pushed early stream 2N symbols on 2N consecutive cycles when i_sym_ready is held high.
- Symbol order:
  - msb_first = 1: symbol j = word[WORD_W-1-j*SYM_W -: SYM_W].
  - msb_first = 0: symbol j = word[j*SYM_W +: SYM_W].
- Output stability: o_sym_data, o_sym_last and o_word_end hold stable while o_sym_valid && !i_sym_ready.
- o_word_end = o_sym_valid && counter == 0. o_sym_last = o_word_end && the word's last flag.
- o_done pulses high for exactly one cycle after the edge on which the o_sym_last symbol is handshaked.
- Simultaneous push and pop in one cycle: both occur; o_level is unchanged.
- Pointers wrap modulo DEPTH. The full flag is derived from occupancy, so full and empty are never ambiguous.

Optional Feature:
- Macro: WORD_SYMBOL_SERIALIZER_STATS_EN.
- Defined: adds output o_sym_cnt, 16 bits.
  - Increments on every symbol handshake and saturates at 16'hFFFF.
  - Clears to 0 on reset and on the edge after the o_done pulse, so it is 0 again when the next frame starts.
  - Holds the frame total during the o_done cycle.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- 16'hAAAA, MSB-first, last=1, sym_ready held 1 -> 8 symbols 2'b10, the first valid 2 edges after the push; o_sym_last and o_word_end on symbol 8; o_done one cycle later; o_sym_cnt = 8.
- 16'h1234, MSB-first -> symbols 0,1,0,2,0,3,1,0. The same word LSB-first -> 0,1,3,0,2,0,1,0.
- Words 16'h1234 (last=0) then 16'hAAAA (last=1) pushed back-to-back, sym_ready=1 -> 16 valid symbols on 16 consecutive cycles; o_word_end at 8 and 16; o_sym_last only at 16; exactly one o_done.
- Hold sym_ready=0 and push 5 words -> 1 word in the shift register, o_level = 4, o_in_ready = 0; the 6th word is not accepted; o_sym_data stays at the first symbol. Release sym_ready -> all 40 symbols delivered in order.
- Assert i_rst for 1 cycle at symbol 3 of 16'h1234 (last=1) -> after that edge o_sym_valid = 0, o_level = 0, o_in_ready = 1, no o_done. A new 16'hAAAA then streams normally.
- Alternate sym_ready 1/0 every cycle over a frame of 3 words -> 24 symbols in order, no duplicates or drops, outputs stable during stalls.

Source files
------------

// File: rtl/word_symbol_serializer.sv
// Word-to-symbol serializer: FIFO-buffered code words unloaded as WORD_W/SYM_W symbols.
// Optional symbol counter output enabled by WORD_SYMBOL_SERIALIZER_STATS_EN.
module word_symbol_serializer #(
    parameter int WORD_W = 16,
    parameter int SYM_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [WORD_W-1:0]          i_in_data,
    input  logic                       i_in_last,
    input  logic                       i_msb_first,
    output logic                       o_sym_valid,
    input  logic                       i_sym_ready,
    output logic [SYM_W-1:0]           o_sym_data,
    output logic                       o_sym_last,
    output logic                       o_word_end,
    output logic                       o_done,
`ifdef WORD_SYMBOL_SERIALIZER_STATS_EN
    output logic [15:0]                o_sym_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int N  = WORD_W / SYM_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int EW = WORD_W + 2;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic                msb_q, msb_d, last_q, last_d, done_q, done_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                full, empty, push, pop, hs;
    logic [EW-1:0]       head;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = i_in_valid && o_in_ready;
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Pop and handshake decode live with the next-state logic: they are the FSM's transitions.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (i_sym_ready) begin
                    hs = 1'b1;
                    if (cnt_q == '0) begin
                        if (!empty) pop = 1'b1;
                        else        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_sym_valid = (state_q == SHIFT);
        o_word_end  = o_sym_valid && (cnt_q == '0);
        o_sym_last  = o_word_end && last_q;
        o_sym_data  = msb_q ? sh_q[WORD_W-1 -: SYM_W] : sh_q[SYM_W-1:0];
        o_in_ready  = !full && !i_rst;
        o_level     = level_q;
        o_done      = done_q;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
        sh_d   = sh_q;
        msb_d  = msb_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        done_d = hs && (cnt_q == '0) && last_q;
        if (pop) begin
            sh_d   = head[EW-1:2];
            last_d = head[1];
            msb_d  = head[0];
            cnt_d  = CW'(N-1);
        end else if (hs && cnt_q != '0) begin
            // The emitted symbol always sits at the end selected by msb_q.
            sh_d  = msb_q ? (sh_q << SYM_W) : (sh_q >> SYM_W);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {i_in_data, i_in_last, i_msb_first};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sh_q     <= '0;
            msb_q    <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sh_q     <= sh_d;
            msb_q    <= msb_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

`ifdef WORD_SYMBOL_SERIALIZER_STATS_EN
    logic [15:0] sym_cnt_q, sym_cnt_d;

    // A handshake in the o_done cycle belongs to the next frame, so it seeds the count.
    always_comb begin
        sym_cnt_d = sym_cnt_q;
        if (done_q)                           sym_cnt_d = hs ? 16'd1 : '0;
        else if (hs && sym_cnt_q != 16'hFFFF) sym_cnt_d = sym_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) sym_cnt_q <= '0;
        else       sym_cnt_q <= sym_cnt_d;
    end

    assign o_sym_cnt = sym_cnt_q;
`endif

endmodule
